fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the 5-stage MIPS32 core. It owns the fetch PC and issues requests to instruction memory, which may insert wait states. It delivers `instrD`/`opCode`/`func`/`pcPlus4D` to the decode-stage controller and acts on that controller's `pcSrcD`/`jump` redirects. It is the producer end of the decode interface: it supplies the fields the controller decodes and consumes the branch/jump decisions the controller returns.

## Interface
- `RESET_PC`, 32'h0000_0000, fetch address after reset
- `clk`  in  1  clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `stallD`  in  1  hazard-unit stall; holds the IF/ID register
- `pcSrcD`  in  1  taken conditional branch in decode
- `pcBranchD`  in  32  branch target from decode
- `jump`  in  1  unconditional jump in decode
- `imemReq`  out  1  fetch request
- `imemAddr`  out  32  fetch address (= pcF)
- `imemRdata`  in  32  fetched word
- `imemValid`  in  1  `imemRdata` valid; may assert in the same cycle as `imemReq` or any later cycle
- `instrD`  out  32  IF/ID instruction (0 = nop when bubble)
- `opCode`  out  6  `instrD[31:26]`
- `func`  out  6  `instrD[5:0]`
- `pcPlus4D`  out  32  IF/ID PC+4
- `validD`  out  1  IF/ID holds a real instruction
- `fetchBusy`  out  1  a request is outstanding and no data has been returned this cycle

## Operation
- States:
  - FETCH: request outstanding.
  - HOLD: word captured in the skid buffer; D is stalled.
  - DROP: redirected while a request was in flight; discard the next response.
- `redirect = (pcSrcD | jump) & validD & ~stallD`. `pcSrcD` has priority over `jump`.
- Redirect target:
  - `pcSrcD`: `pcBranchD`.
  - `jump`: `{pcPlus4D[31:28], instrD[25:0], 2'b00}`.
- `imemReq = ~rst & (state==FETCH | state==DROP)`. `imemAddr = pcF`, held stable until `imemValid`.
- FETCH, `imemValid=1`:
  - If `redirect`: discard the word; `pcF <= target`; IF/ID is flushed (`instrD<=0`, `validD<=0`); stay in FETCH.
  - Else if `stallD=0`: `instrD<=imemRdata`, `pcPlus4D<=pcF+4`, `validD<=1`, `pcF<=pcF+4`.
  - Else (`stallD=1`): `buf<=imemRdata`, `bufPc4<=pcF+4`, `pcF<=pcF+4`; go to HOLD. IF/ID unchanged.
- FETCH, `imemValid=0`:
  - If `redirect`: `pcF<=target`; flush IF/ID; go to DROP.
  - Else if `stallD=0`: insert a bubble (`instrD<=0`, `validD<=0`).
  - Else: IF/ID unchanged.
- DROP:
  - `imemAddr` still carries the old address until its `imemValid`; pcF already holds the target, so the old address is kept in a separate register.
  - Response is discarded. Next state is FETCH.
  - IF/ID takes bubbles while `stallD=0`.
- HOLD: `imemReq=0`.
  - `stallD=1`: no change.
  - `stallD=0` and `redirect`: discard `buf`; `pcF<=target`; flush IF/ID; go to FETCH.
  - `stallD=0`, no redirect: `instrD<=buf`, `pcPlus4D<=bufPc4`, `validD<=1`; go to FETCH.
- `fetchBusy = imemReq & ~imemValid`.
- PC arithmetic is modulo 2^32: `32'hFFFF_FFFC + 4 = 0`. No alignment check.

## Timing
- Reset (`rst=1` at a clock edge):
  - `pcF=RESET_PC`, state FETCH.
  - `instrD=0`, `pcPlus4D=0`, `validD=0`, `buf=0`.
  - `imemReq=0` while `rst=1`.
- First request (`imemAddr=RESET_PC`) in the first cycle with `rst=0`.
- Latency: word returned in cycle N appears on `instrD` in cycle N+1.
- Zero-wait memory sustains 1 instruction/cycle.
- Redirect is registered: the target appears on `imemAddr` the cycle after `redirect`, unless in DROP.
- In DROP, the target appears the cycle after the dropped `imemValid`.
- The delay-slot instruction is always flushed; there is no architectural delay slot.
- `rst` mid-transaction aborts any state. An in-flight memory response arriving after reset is ignored, because `imemReq=0` during `rst` and the memory must not hold `imemValid` across reset.

## Test plan
- Reset `RESET_PC=0`, zero-wait memory returning `addr|32'hA000_0000` → `imemAddr` 0,4,8,…; `instrD` 0xA0000000, 0xA0000004 one cycle later; `validD=1` continuous; `opCode`/`func` slices correct.
- 3-wait-state memory → `imemAddr` stable for 4 cycles; `fetchBusy=1` for 3 cycles; `validD=0` bubbles for 3 cycles; then the word is in D.
- `stallD=1` for 2 cycles while a word returns → HOLD with `imemReq=0`; IF/ID unchanged; on release `instrD=buf` and the next request is to pc+4.
- `pcSrcD=1`, `pcBranchD=0x100`, `validD=1` → next `imemAddr=0x100`; `validD=0` next cycle; the sequential word never appears on `instrD`.
- `jump` with `instrD[25:0]=0x0000040`, `pcPlus4D=0x0040_0008` → next `imemAddr=0x0000_0100`. Repeat with a request pending and 2 wait states → DROP; the dropped word never reaches `instrD`; the fetch to 0x100 issues after the drop.
- `RESET_PC=32'hFFFF_FFFC`, zero-wait → `imemAddr` 0xFFFFFFFC then 0x0; `pcPlus4D=0`. Assert `rst` mid-HOLD → all outputs return to reset values next cycle.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Decode-side and instruction-memory signals of the fetch stage.
// The master modport is the fetch stage; the slave modport is the decode stage plus memory.
interface fetch_stage_if;
  logic        stallD;
  logic        pcSrcD;
  logic [31:0] pcBranchD;
  logic        jump;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic [31:0] imemRdata;
  logic        imemValid;
  logic [31:0] instrD;
  logic [5:0]  opCode;
  logic [5:0]  func;
  logic [31:0] pcPlus4D;
  logic        validD;
  logic        fetchBusy;

  modport master (
    input  stallD, pcSrcD, pcBranchD, jump, imemRdata, imemValid,
    output imemReq, imemAddr, instrD, opCode, func, pcPlus4D, validD, fetchBusy
  );

  modport slave (
    output stallD, pcSrcD, pcBranchD, jump, imemRdata, imemValid,
    input  imemReq, imemAddr, instrD, opCode, func, pcPlus4D, validD, fetchBusy
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch with wait-state tolerant memory handshake, one-word skid buffer
// for decode stalls, and the IF/ID pipeline register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);

  typedef enum logic [1:0] {StFetch, StHold, StDrop} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] buf_pc4_q, buf_pc4_d;
  logic [31:0] drop_addr_q, drop_addr_d;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic        imem_req;

  always_comb begin
    redirect = (bus.pcSrcD | bus.jump) & valid_q & ~bus.stallD;
    target   = bus.pcSrcD ? bus.pcBranchD : {pc4_q[31:28], instr_q[25:0], 2'b00};
    pc_plus4 = pc_q + 32'd4;
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    pc4_d       = pc4_q;
    valid_d     = valid_q;
    buf_d       = buf_q;
    buf_pc4_d   = buf_pc4_q;
    drop_addr_d = drop_addr_q;
    unique case (state_q)
      StFetch: begin
        if (redirect) begin
          pc_d    = target;
          instr_d = '0;
          valid_d = 1'b0;
          // The old request is still on the bus; remember its address until it completes.
          if (!bus.imemValid) begin
            drop_addr_d = pc_q;
            state_d     = StDrop;
          end
        end else if (bus.imemValid) begin
          pc_d = pc_plus4;
          if (bus.stallD) begin
            buf_d     = bus.imemRdata;
            buf_pc4_d = pc_plus4;
            state_d   = StHold;
          end else begin
            instr_d = bus.imemRdata;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
          end
        end else if (!bus.stallD) begin
          instr_d = '0;
          valid_d = 1'b0;
        end
      end
      StHold: begin
        if (!bus.stallD) begin
          state_d = StFetch;
          if (redirect) begin
            pc_d    = target;
            instr_d = '0;
            valid_d = 1'b0;
          end else begin
            instr_d = buf_q;
            pc4_d   = buf_pc4_q;
            valid_d = 1'b1;
          end
        end
      end
      StDrop: begin
        if (!bus.stallD) begin
          instr_d = '0;
          valid_d = 1'b0;
        end
        if (bus.imemValid) begin
          state_d = StFetch;
        end
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StFetch;
      pc_q        <= RESET_PC;
      instr_q     <= '0;
      pc4_q       <= '0;
      valid_q     <= 1'b0;
      buf_q       <= '0;
      buf_pc4_q   <= '0;
      drop_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      pc4_q       <= pc4_d;
      valid_q     <= valid_d;
      buf_q       <= buf_d;
      buf_pc4_q   <= buf_pc4_d;
      drop_addr_q <= drop_addr_d;
    end
  end

  assign imem_req      = ~rst & ((state_q == StFetch) | (state_q == StDrop));
  assign bus.imemReq   = imem_req;
  assign bus.imemAddr  = (state_q == StDrop) ? drop_addr_q : pc_q;
  assign bus.fetchBusy = imem_req & ~bus.imemValid;
  assign bus.instrD    = instr_q;
  assign bus.opCode    = instr_q[31:26];
  assign bus.func      = instr_q[5:0];
  assign bus.pcPlus4D  = pc4_q;
  assign bus.validD    = valid_q;

  // A pending request must keep its address until the memory answers.
  a_addr_stable: assert property (@(posedge clk) disable iff (rst)
    (imem_req && !bus.imemValid) |=> $stable(bus.imemAddr));

  a_no_req_in_hold: assert property (@(posedge clk) disable iff (rst)
    (state_q == StHold) |-> !imem_req);

endmodule

// File: tb/tb_fetch_stage.sv
// Random stimulus bench: two fetch stages (RESET_PC 0 and FFFF_FFFC) against a
// transaction-level model of pending request, skid word, discard flag and IF/ID contents.
module tb_fetch_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        stall, pc_src, jmp;
  logic [31:0] br_tgt;
  logic        valid_k [2];
  int          wait_left;
  int          n_cmp, n_err;

  fetch_stage_if if0 ();
  fetch_stage_if if1 ();

  fetch_stage #(.RESET_PC(32'h0000_0000)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:28] ^ 4'hA, a[27:0]};
  endfunction

  function automatic logic [31:0] reset_pc(input int k);
    return (k == 0) ? 32'h0000_0000 : 32'hFFFF_FFFC;
  endfunction

  assign if0.stallD    = stall;
  assign if0.pcSrcD    = pc_src;
  assign if0.jump      = jmp;
  assign if0.pcBranchD = br_tgt;
  assign if0.imemValid = valid_k[0];
  assign if0.imemRdata = mem_word(if0.imemAddr);
  assign if1.stallD    = stall;
  assign if1.pcSrcD    = pc_src;
  assign if1.jump      = jmp;
  assign if1.pcBranchD = br_tgt;
  assign if1.imemValid = valid_k[1];
  assign if1.imemRdata = mem_word(if1.imemAddr);

  logic        o_req [2], o_valid [2], o_busy [2];
  logic [31:0] o_addr [2], o_instr [2], o_pc4 [2];
  logic [5:0]  o_op [2], o_fn [2];
  assign o_req[0]   = if0.imemReq;   assign o_req[1]   = if1.imemReq;
  assign o_addr[0]  = if0.imemAddr;  assign o_addr[1]  = if1.imemAddr;
  assign o_busy[0]  = if0.fetchBusy; assign o_busy[1]  = if1.fetchBusy;
  assign o_instr[0] = if0.instrD;    assign o_instr[1] = if1.instrD;
  assign o_op[0]    = if0.opCode;    assign o_op[1]    = if1.opCode;
  assign o_fn[0]    = if0.func;      assign o_fn[1]    = if1.func;
  assign o_pc4[0]   = if0.pcPlus4D;  assign o_pc4[1]   = if1.pcPlus4D;
  assign o_valid[0] = if0.validD;    assign o_valid[1] = if1.validD;

  // Model: next fetch address, in-flight address to be discarded, skid word, IF/ID contents.
  logic [31:0] m_pc [2], m_old [2], m_skid [2], m_skid_pc4 [2], m_instr [2], m_pc4 [2];
  logic        m_valid [2], m_skid_full [2], m_discard [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_dut(input int k);
    logic        e_req;
    logic [31:0] e_addr;
    e_req  = !rst && !m_skid_full[k];
    e_addr = m_discard[k] ? m_old[k] : m_pc[k];
    check_eq($sformatf("d%0d.imemReq", k),   32'(o_req[k]),   32'(e_req));
    if (e_req) check_eq($sformatf("d%0d.imemAddr", k), o_addr[k], e_addr);
    check_eq($sformatf("d%0d.fetchBusy", k), 32'(o_busy[k]),  32'(e_req && !valid_k[k]));
    check_eq($sformatf("d%0d.instrD", k),    o_instr[k],      m_instr[k]);
    check_eq($sformatf("d%0d.opCode", k),    32'(o_op[k]),    32'(m_instr[k][31:26]));
    check_eq($sformatf("d%0d.func", k),      32'(o_fn[k]),    32'(m_instr[k][5:0]));
    check_eq($sformatf("d%0d.pcPlus4D", k),  o_pc4[k],        m_pc4[k]);
    check_eq($sformatf("d%0d.validD", k),    32'(o_valid[k]), 32'(m_valid[k]));
  endtask

  task automatic model_step(input int k);
    logic        redir, val;
    logic [31:0] tgt;
    val = valid_k[k];
    if (rst) begin
      m_pc[k] = reset_pc(k);   m_old[k] = '0;      m_skid_full[k] = 1'b0;
      m_discard[k] = 1'b0;     m_instr[k] = '0;    m_pc4[k] = '0;   m_valid[k] = 1'b0;
      return;
    end
    redir = (pc_src || jmp) && m_valid[k] && !stall;
    tgt   = pc_src ? br_tgt : {m_pc4[k][31:28], m_instr[k][25:0], 2'b00};
    if (m_skid_full[k]) begin
      if (!stall) begin
        if (redir) begin
          m_pc[k] = tgt; m_instr[k] = '0; m_valid[k] = 1'b0;
        end else begin
          m_instr[k] = m_skid[k]; m_pc4[k] = m_skid_pc4[k]; m_valid[k] = 1'b1;
        end
        m_skid_full[k] = 1'b0;
      end
    end else if (m_discard[k]) begin
      if (!stall) begin m_instr[k] = '0; m_valid[k] = 1'b0; end
      if (val) m_discard[k] = 1'b0;
    end else if (redir) begin
      if (!val) begin m_old[k] = m_pc[k]; m_discard[k] = 1'b1; end
      m_pc[k] = tgt; m_instr[k] = '0; m_valid[k] = 1'b0;
    end else if (val) begin
      if (stall) begin
        m_skid[k] = mem_word(m_pc[k]); m_skid_pc4[k] = m_pc[k] + 32'd4; m_skid_full[k] = 1'b1;
      end else begin
        m_instr[k] = mem_word(m_pc[k]); m_pc4[k] = m_pc[k] + 32'd4; m_valid[k] = 1'b1;
      end
      m_pc[k] = m_pc[k] + 32'd4;
    end else if (!stall) begin
      m_instr[k] = '0; m_valid[k] = 1'b0;
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0; wait_left = 0;
    stall = 1'b0; pc_src = 1'b0; jmp = 1'b0; br_tgt = '0;
    valid_k[0] = 1'b0; valid_k[1] = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk);
      #1;
      rst    = (cyc < 2) || ($urandom_range(0, 79) == 0);
      stall  = (cyc > 40) && ($urandom_range(0, 3) == 0);
      pc_src = (cyc > 20) && ($urandom_range(0, 11) == 0);
      jmp    = (cyc > 20) && ($urandom_range(0, 11) == 0);
      br_tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      #1;
      for (int k = 0; k < 2; k++) valid_k[k] = o_req[k] && (wait_left == 0);
      #1;
      if (cyc > 0) begin
        check_dut(0);
        check_dut(1);
      end
      model_step(0);
      model_step(1);
      if (o_req[0]) begin
        if (valid_k[0]) begin
          wait_left = (cyc < 20 || $urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
        end else begin
          wait_left--;
        end
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
